// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core.
// Contents: FSM state enum, digit-select encodings for the load port,
// BCD digit type, per-digit clamp limits and a clamp helper.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } sw_state_e;

   typedef logic [1:0] ld_sel_t;
   localparam ld_sel_t SEL_SEC_ONES = 2'd0;
   localparam ld_sel_t SEL_SEC_TENS = 2'd1;
   localparam ld_sel_t SEL_MIN_ONES = 2'd2;
   localparam ld_sel_t SEL_MIN_TENS = 2'd3;

   typedef logic [3:0] bcd_t;

   localparam bcd_t SEC_TENS_MAX = 4'd5;
   localparam bcd_t DIGIT_MAX    = 4'd9;

   // Saturate a loaded digit to the largest value its position can show.
   function automatic bcd_t clamp_digit(bcd_t val, bcd_t lim);
      return (val > lim) ? lim : val;
   endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Control/status bundle between the button logic (master) and the
// stopwatch core (slave).
// Controls : start_stop, clear, mode_down, ld_en, ld_sel[1:0], ld_val[3:0]
// Status   : min_tens, min_ones, sec_tens, sec_ones (BCD), frac[FRAC_W],
//            total_sec[SEC_W], running, done
interface stopwatch_core_if #(
   parameter int TICK_HZ = 100,
   parameter int MAX_MIN = 99
);
   localparam int FRAC_W = $clog2(TICK_HZ);
   localparam int SEC_W  = $clog2(MAX_MIN * 60 + 60);

   logic              start_stop;
   logic              clear;
   logic              mode_down;
   logic              ld_en;
   logic [1:0]        ld_sel;
   logic [3:0]        ld_val;
   logic [3:0]        min_tens;
   logic [3:0]        min_ones;
   logic [3:0]        sec_tens;
   logic [3:0]        sec_ones;
   logic [FRAC_W-1:0] frac;
   logic [SEC_W-1:0]  total_sec;
   logic              running;
   logic              done;

   modport master (
      output start_stop, clear, mode_down, ld_en, ld_sel, ld_val,
      input  min_tens, min_ones, sec_tens, sec_ones, frac, total_sec, running, done
   );

   modport slave (
      input  start_stop, clear, mode_down, ld_en, ld_sel, ld_val,
      output min_tens, min_ones, sec_tens, sec_ones, frac, total_sec, running, done
   );
endinterface

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every PRESC enabled cycles.
// Ports: clk, rst_n (async, active low), en (count enable; phase is held
// while low), clr (force phase to 0), tick (high on the wrap cycle).
module tick_gen #(
   parameter int PRESC = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);
   localparam int CNT_W = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESC - 1);

   logic [CNT_W-1:0] cnt_r;

   // Phase counter: advances only while enabled so a pause/resume keeps phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (en) begin
         cnt_r <= (cnt_r == CNT_LAST) ? '0 : cnt_r + 1'b1;
      end
   end

   assign tick = en && (cnt_r == CNT_LAST);
endmodule

// File: rtl/stopwatch_core.sv
// Up/down stopwatch core counting MM:SS.ff with run/pause, clear and
// per-digit preload.
// Ports: clk, rst_n (async, active low), sw (stopwatch_core_if.slave):
// pulse controls in, BCD digits / frac / binary total seconds / running /
// one-cycle done pulse out.
module stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ  = 100_000_000,
   parameter int TICK_HZ = 100,
   parameter int MAX_MIN = 99
) (
   input  logic             clk,
   input  logic             rst_n,
   stopwatch_core_if.slave  sw
);
   localparam int PRESC  = CLK_HZ / TICK_HZ;
   localparam int FRAC_W = $clog2(TICK_HZ);
   localparam int SEC_W  = $clog2(MAX_MIN * 60 + 60);
   localparam logic [FRAC_W-1:0] FRAC_LAST = FRAC_W'(TICK_HZ - 1);
   localparam bcd_t MAX_MT = 4'(MAX_MIN / 10);
   localparam bcd_t MAX_MO = 4'(MAX_MIN % 10);

   function automatic logic [SEC_W-1:0] bcd_to_sec(bcd_t mt, bcd_t mo, bcd_t st, bcd_t so);
      int s;
      s = int'(mt) * 32'sd600 + int'(mo) * 32'sd60 + int'(st) * 32'sd10 + int'(so);
      return SEC_W'(s);
   endfunction

   sw_state_e         state_r, state_nxt_s;
   logic              dir_down_r, dir_nxt_s;
   bcd_t              mt_r, mo_r, st_r, so_r;
   bcd_t              mt_nxt_s, mo_nxt_s, st_nxt_s, so_nxt_s;
   logic [FRAC_W-1:0] frac_r, frac_nxt_s;
   logic [SEC_W-1:0]  total_sec_r;
   logic              done_r, done_nxt_s;
   logic              presc_en_s, presc_clr_s, tick_s;
   bcd_t              up_mt_s, up_mo_s, up_st_s, up_so_s;
   bcd_t              dn_mt_s, dn_mo_s, dn_st_s, dn_so_s;
   logic [FRAC_W-1:0] up_frac_s, dn_frac_s;
   bcd_t              ld_mt_raw_s, ld_mo_raw_s, ld_mt_s, ld_mo_s, ld_st_s, ld_so_s;
   logic              at_max_s, is_zero_s, dn_zero_s, min_over_s;

   assign presc_en_s = (state_r == RUN);

   tick_gen #(.PRESC(PRESC)) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (presc_en_s),
      .clr   (presc_clr_s),
      .tick  (tick_s)
   );

   // One-tick increment with BCD carries frac -> seconds -> minutes.
   always_comb begin
      up_mt_s = mt_r; up_mo_s = mo_r; up_st_s = st_r; up_so_s = so_r;
      up_frac_s = frac_r + 1'b1;
      if (frac_r == FRAC_LAST) begin
         up_frac_s = '0;
         if (so_r == 4'd9) begin
            up_so_s = 4'd0;
            if (st_r == 4'd5) begin
               up_st_s = 4'd0;
               if (mo_r == 4'd9) begin
                  up_mo_s = 4'd0;
                  up_mt_s = mt_r + 4'd1;
               end else begin
                  up_mo_s = mo_r + 4'd1;
               end
            end else begin
               up_st_s = st_r + 4'd1;
            end
         end else begin
            up_so_s = so_r + 4'd1;
         end
      end else begin
         up_frac_s = frac_r + 1'b1;
      end
   end

   // One-tick decrement with BCD borrows; never evaluated at 00:00.0.
   always_comb begin
      dn_mt_s = mt_r; dn_mo_s = mo_r; dn_st_s = st_r; dn_so_s = so_r;
      dn_frac_s = frac_r - 1'b1;
      if (frac_r == '0) begin
         dn_frac_s = FRAC_LAST;
         if (so_r == 4'd0) begin
            dn_so_s = 4'd9;
            if (st_r == 4'd0) begin
               dn_st_s = 4'd5;
               if (mo_r == 4'd0) begin
                  dn_mo_s = 4'd9;
                  dn_mt_s = mt_r - 4'd1;
               end else begin
                  dn_mo_s = mo_r - 4'd1;
               end
            end else begin
               dn_st_s = st_r - 4'd1;
            end
         end else begin
            dn_so_s = so_r - 4'd1;
         end
      end else begin
         dn_frac_s = frac_r - 1'b1;
      end
   end

   // Digit preload: clamp the written digit, then clamp minutes to MAX_MIN.
   always_comb begin
      ld_mt_raw_s = mt_r; ld_mo_raw_s = mo_r; ld_st_s = st_r; ld_so_s = so_r;
      case (sw.ld_sel)
         SEL_SEC_ONES: ld_so_s     = clamp_digit(sw.ld_val, DIGIT_MAX);
         SEL_SEC_TENS: ld_st_s     = clamp_digit(sw.ld_val, SEC_TENS_MAX);
         SEL_MIN_ONES: ld_mo_raw_s = clamp_digit(sw.ld_val, DIGIT_MAX);
         SEL_MIN_TENS: ld_mt_raw_s = clamp_digit(sw.ld_val, DIGIT_MAX);
         default:      ld_so_s     = so_r;
      endcase
      min_over_s = (int'(ld_mt_raw_s) * 32'sd10 + int'(ld_mo_raw_s)) > MAX_MIN;
      ld_mt_s = min_over_s ? MAX_MT : ld_mt_raw_s;
      ld_mo_s = min_over_s ? MAX_MO : ld_mo_raw_s;
   end

   assign at_max_s  = (mt_r == MAX_MT) && (mo_r == MAX_MO) && (st_r == 4'd5) &&
                      (so_r == 4'd9) && (frac_r == FRAC_LAST);
   assign is_zero_s = (mt_r == 4'd0) && (mo_r == 4'd0) && (st_r == 4'd0) &&
                      (so_r == 4'd0) && (frac_r == '0);
   assign dn_zero_s = (dn_mt_s == 4'd0) && (dn_mo_s == 4'd0) && (dn_st_s == 4'd0) &&
                      (dn_so_s == 4'd0) && (dn_frac_s == '0);

   // Next-state and next-count logic; clear beats start_stop beats ld_en.
   always_comb begin
      state_nxt_s = state_r;
      dir_nxt_s   = dir_down_r;
      mt_nxt_s = mt_r; mo_nxt_s = mo_r; st_nxt_s = st_r; so_nxt_s = so_r;
      frac_nxt_s  = frac_r;
      done_nxt_s  = 1'b0;
      presc_clr_s = 1'b0;
      if (sw.clear) begin
         state_nxt_s = IDLE;
         mt_nxt_s = 4'd0; mo_nxt_s = 4'd0; st_nxt_s = 4'd0; so_nxt_s = 4'd0;
         frac_nxt_s  = '0;
         presc_clr_s = 1'b1;
      end else begin
         case (state_r)
            IDLE, PAUSE: begin
               if (sw.start_stop) begin
                  state_nxt_s = RUN;
                  // Resume from PAUSE keeps direction and prescaler phase.
                  if (state_r == IDLE) begin
                     dir_nxt_s   = sw.mode_down;
                     presc_clr_s = 1'b1;
                  end else begin
                     dir_nxt_s   = dir_down_r;
                  end
               end else if (sw.ld_en) begin
                  mt_nxt_s = ld_mt_s; mo_nxt_s = ld_mo_s; st_nxt_s = ld_st_s; so_nxt_s = ld_so_s;
                  frac_nxt_s = '0;
               end else begin
                  state_nxt_s = state_r;
               end
            end
            RUN: begin
               if (dir_down_r && is_zero_s) begin
                  // Countdown started from zero terminates without a tick.
                  state_nxt_s = DONE;
                  done_nxt_s  = 1'b1;
               end else if (tick_s && !dir_down_r && at_max_s) begin
                  state_nxt_s = DONE;
                  done_nxt_s  = 1'b1;
               end else if (tick_s) begin
                  if (dir_down_r) begin
                     mt_nxt_s = dn_mt_s; mo_nxt_s = dn_mo_s; st_nxt_s = dn_st_s; so_nxt_s = dn_so_s;
                     frac_nxt_s = dn_frac_s;
                  end else begin
                     mt_nxt_s = up_mt_s; mo_nxt_s = up_mo_s; st_nxt_s = up_st_s; so_nxt_s = up_so_s;
                     frac_nxt_s = up_frac_s;
                  end
                  // A tick coinciding with start_stop is still counted.
                  if (dir_down_r && dn_zero_s) begin
                     state_nxt_s = DONE;
                     done_nxt_s  = 1'b1;
                  end else if (sw.start_stop) begin
                     state_nxt_s = PAUSE;
                  end else begin
                     state_nxt_s = RUN;
                  end
               end else if (sw.start_stop) begin
                  state_nxt_s = PAUSE;
               end else begin
                  state_nxt_s = RUN;
               end
            end
            DONE:    state_nxt_s = DONE;
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // State, count and registered outputs; total_sec tracks the next digits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         dir_down_r  <= 1'b0;
         mt_r        <= 4'd0;
         mo_r        <= 4'd0;
         st_r        <= 4'd0;
         so_r        <= 4'd0;
         frac_r      <= '0;
         total_sec_r <= '0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         dir_down_r  <= dir_nxt_s;
         mt_r        <= mt_nxt_s;
         mo_r        <= mo_nxt_s;
         st_r        <= st_nxt_s;
         so_r        <= so_nxt_s;
         frac_r      <= frac_nxt_s;
         total_sec_r <= bcd_to_sec(mt_nxt_s, mo_nxt_s, st_nxt_s, so_nxt_s);
         done_r      <= done_nxt_s;
      end
   end

   assign sw.min_tens  = mt_r;
   assign sw.min_ones  = mo_r;
   assign sw.sec_tens  = st_r;
   assign sw.sec_ones  = so_r;
   assign sw.frac      = frac_r;
   assign sw.total_sec = total_sec_r;
   assign sw.running   = (state_r == RUN);
   assign sw.done      = done_r;
endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;
   localparam int CLK_HZ  = 1000;
   localparam int TICK_HZ = 10;
   localparam int MAX_MIN = 99;
   localparam int PRESC   = CLK_HZ / TICK_HZ;
   localparam int FRAC_W  = $clog2(TICK_HZ);
   localparam int SEC_W   = $clog2(MAX_MIN * 60 + 60);
   localparam int VW      = 16 + FRAC_W + SEC_W + 2;
   localparam int TMAX    = (MAX_MIN * 60 + 59) * TICK_HZ + TICK_HZ - 1;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   bit   cur_md;

   // Reference model: the whole count is one integer number of ticks.
   int   m_t, m_ph, m_state;
   bit   m_down, m_done;

   stopwatch_core_if #(.TICK_HZ(TICK_HZ), .MAX_MIN(MAX_MIN)) swi ();

   stopwatch_core #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MAX_MIN(MAX_MIN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sw    (swi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int load_model(int t, int sel, int val);
      int s, m, lim;
      int d[4];
      s = t / TICK_HZ;
      d[3] = (s / 60) / 10; d[2] = (s / 60) % 10; d[1] = (s % 60) / 10; d[0] = s % 10;
      lim = (sel == 1) ? 5 : 9;
      d[sel] = (val > lim) ? lim : val;
      m = d[3] * 10 + d[2];
      if (m > MAX_MIN) m = MAX_MIN;
      return (m * 60 + d[1] * 10 + d[0]) * TICK_HZ;
   endfunction

   task automatic model_reset();
      m_t = 0; m_ph = 0; m_state = M_IDLE; m_down = 1'b0; m_done = 1'b0;
   endtask

   task automatic model_step(bit ss, bit clr, bit md, bit le, int sel, int val);
      bit tk;
      m_done = 1'b0;
      if (clr) begin
         m_state = M_IDLE; m_t = 0; m_ph = 0;
      end else begin
         case (m_state)
            M_IDLE, M_PAUSE: begin
               if (ss) begin
                  if (m_state == M_IDLE) begin m_down = md; m_ph = 0; end
                  m_state = M_RUN;
               end else if (le) begin
                  m_t = load_model(m_t, sel, val);
               end
            end
            M_RUN: begin
               tk = (m_ph == PRESC - 1);
               m_ph = (m_ph + 1) % PRESC;
               if (m_down && m_t == 0) begin
                  m_state = M_DONE; m_done = 1'b1;
               end else if (tk) begin
                  if (!m_down && m_t == TMAX) begin
                     m_state = M_DONE; m_done = 1'b1;
                  end else begin
                     m_t = m_down ? m_t - 1 : m_t + 1;
                     if (m_down && m_t == 0) begin m_state = M_DONE; m_done = 1'b1; end
                     else if (ss) m_state = M_PAUSE;
                  end
               end else if (ss) begin
                  m_state = M_PAUSE;
               end
            end
            default: ;
         endcase
      end
   endtask

   function automatic logic [VW-1:0] exp_vec();
      int s, m;
      s = m_t / TICK_HZ;
      m = s / 60;
      return {4'(m / 10), 4'(m % 10), 4'((s % 60) / 10), 4'(s % 10),
              FRAC_W'(m_t % TICK_HZ), SEC_W'(s), (m_state == M_RUN), m_done};
   endfunction

   function automatic logic [VW-1:0] dut_vec();
      return {swi.min_tens, swi.min_ones, swi.sec_tens, swi.sec_ones,
              swi.frac, swi.total_sec, swi.running, swi.done};
   endfunction

   // Drive one clock cycle of inputs (set at negedge, sampled by the next posedge).
   task automatic cycle(bit ss, bit clr, bit md, bit le, int sel, int val);
      swi.start_stop = ss; swi.clear = clr; swi.mode_down = md; swi.ld_en = le;
      swi.ld_sel = 2'(sel); swi.ld_val = 4'(val);
      model_step(ss, clr, md, le, sel, val);
      @(negedge clk);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, cur_md, 1'b0, 0, 0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      swi.start_stop = 1'b0; swi.clear = 1'b0; swi.mode_down = 1'b0; swi.ld_en = 1'b0;
      swi.ld_sel = 2'd0; swi.ld_val = 4'd0;
      model_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if (dut_vec() !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got %h expected 0", dut_vec());
      end
      rst_n = 1'b1;
      idle(2);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
         n_fail++; $display("FAIL reset_idle: got %h expected %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_up_count();
      cur_md = 1'b0;
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      idle(PRESC - 1);
      n_checks++;
      if (swi.frac !== FRAC_W'(0)) begin
         n_fail++; $display("FAIL first_tick_early: got frac %0d expected 0", swi.frac);
      end
      idle(1);
      n_checks++;
      if (swi.frac !== FRAC_W'(1)) begin
         n_fail++; $display("FAIL first_tick: got frac %0d expected 1", swi.frac);
      end
      idle(10000 - PRESC);
      n_checks++;
      if ({swi.min_tens, swi.min_ones, swi.sec_tens, swi.sec_ones, swi.frac} !== {16'h0010, FRAC_W'(0)}
          || swi.total_sec !== SEC_W'(10) || swi.running !== 1'b1) begin
         n_fail++; $display("FAIL up_10s: got %h expected 00:10.0 total 10", dut_vec());
      end
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
         n_fail++; $display("FAIL up_model: got %h expected %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_pause_resume();
      logic [VW-1:0] snap;
      cur_md = 1'b0;
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      idle(5337);
      n_checks++;
      if ({swi.sec_ones, swi.frac} !== {4'd5, FRAC_W'(3)}) begin
         n_fail++; $display("FAIL run_5_3: got %0d.%0d expected 5.3", swi.sec_ones, swi.frac);
      end
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      snap = dut_vec();
      idle(500);
      n_checks++;
      if (dut_vec() !== snap || swi.running !== 1'b0) begin
         n_fail++; $display("FAIL pause_frozen: got %h expected %h", dut_vec(), snap);
      end
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      idle(PRESC - 38 - 1);
      n_checks++;
      if (swi.frac !== FRAC_W'(3) || swi.running !== 1'b1) begin
         n_fail++; $display("FAIL resume_early: got frac %0d expected 3", swi.frac);
      end
      idle(1);
      n_checks++;
      if (swi.frac !== FRAC_W'(4)) begin
         n_fail++; $display("FAIL resume_phase: got frac %0d expected 4", swi.frac);
      end
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
         n_fail++; $display("FAIL pause_model: got %h expected %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_up_terminal();
      int pulses, at;
      cur_md = 1'b0;
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 3, 9);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 2, 9);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1, 9);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 0, 9);
      n_checks++;
      if ({swi.min_tens, swi.min_ones, swi.sec_tens, swi.sec_ones} !== 16'h9959 || swi.total_sec !== SEC_W'(5999)) begin
         n_fail++; $display("FAIL preload_9959: got %h expected 99:59 total 5999", dut_vec());
      end
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      idle(9 * PRESC);
      n_checks++;
      if (swi.frac !== FRAC_W'(9) || swi.done !== 1'b0) begin
         n_fail++; $display("FAIL at_max: got frac %0d done %0d expected 9 0", swi.frac, swi.done);
      end
      pulses = 0; at = -1;
      for (int i = 1; i <= 300; i++) begin
         cycle(i == 150, 1'b0, 1'b0, 1'b0, 0, 0);
         if (swi.done === 1'b1) begin pulses++; at = i; end
      end
      n_checks++;
      if (pulses != 1 || at != PRESC) begin
         n_fail++; $display("FAIL up_done_pulse: got %0d pulses at %0d expected 1 at %0d", pulses, at, PRESC);
      end
      n_checks++;
      if ({swi.min_tens, swi.min_ones, swi.sec_tens, swi.sec_ones, swi.frac} !== {16'h9959, FRAC_W'(9)}
          || swi.running !== 1'b0) begin
         n_fail++; $display("FAIL up_hold: got %h expected 99:59.9 stopped", dut_vec());
      end
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
         n_fail++; $display("FAIL terminal_model: got %h expected %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_down_count();
      int pulses, at;
      cur_md = 1'b1;
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 2, 1);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
      idle(PRESC);
      n_checks++;
      if ({swi.min_tens, swi.min_ones, swi.sec_tens, swi.sec_ones, swi.frac} !== {16'h0059, FRAC_W'(9)}
          || swi.total_sec !== SEC_W'(59)) begin
         n_fail++; $display("FAIL down_first: got %h expected 00:59.9 total 59", dut_vec());
      end
      pulses = 0; at = -1;
      for (int i = 1; i <= 599 * PRESC + 50; i++) begin
         cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
         if (swi.done === 1'b1) begin pulses++; at = i; end
      end
      n_checks++;
      if (pulses != 1 || at != 599 * PRESC) begin
         n_fail++; $display("FAIL down_done_pulse: got %0d pulses at %0d expected 1 at %0d", pulses, at, 599 * PRESC);
      end
      n_checks++;
      if (dut_vec() !== '0) begin
         n_fail++; $display("FAIL down_zero: got %h expected 0", dut_vec());
      end
      // Countdown started at zero finishes on the following cycle.
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
      n_checks++;
      if (swi.running !== 1'b1 || swi.done !== 1'b0) begin
         n_fail++; $display("FAIL zero_start_run: got run %0d done %0d expected 1 0", swi.running, swi.done);
      end
      idle(1);
      n_checks++;
      if (swi.running !== 1'b0 || swi.done !== 1'b1) begin
         n_fail++; $display("FAIL zero_start_done: got run %0d done %0d expected 0 1", swi.running, swi.done);
      end
   endtask

   task automatic test_load_clamp_clear();
      cur_md = 1'b0;
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1, 7);
      n_checks++;
      if (swi.sec_tens !== 4'd5 || swi.total_sec !== SEC_W'(50)) begin
         n_fail++; $display("FAIL clamp_sec_tens: got %0d total %0d expected 5 50", swi.sec_tens, swi.total_sec);
      end
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 0, 3);
      n_checks++;
      if (swi.sec_ones !== 4'd0) begin
         n_fail++; $display("FAIL load_in_run: got %0d expected 0", swi.sec_ones);
      end
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 0, 3);
      idle(1);
      n_checks++;
      if (dut_vec() !== '0) begin
         n_fail++; $display("FAIL clear_wins: got %h expected 0", dut_vec());
      end
   endtask

   task automatic test_async_reset();
      cur_md = 1'b0;
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      idle(1234);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (dut_vec() !== '0) begin
         n_fail++; $display("FAIL async_reset: got %h expected 0", dut_vec());
      end
      @(negedge clk);
      n_checks++;
      if (swi.done !== 1'b0 || swi.running !== 1'b0) begin
         n_fail++; $display("FAIL reset_no_done: got done %0d run %0d expected 0 0", swi.done, swi.running);
      end
      rst_n = 1'b1;
      model_reset();
      idle(3);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
         n_fail++; $display("FAIL post_reset_model: got %h expected %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_random();
      bit ss, clr, le, md;
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         ss  = ($urandom_range(99) < 2);
         clr = ($urandom_range(999) < 3);
         le  = ($urandom_range(99) < 5);
         md  = ($urandom_range(1) == 1);
         cycle(ss, clr, md, le, int'($urandom_range(3)), int'($urandom_range(15)));
         n_checks++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cur_md   = 1'b0;
      test_reset();
      test_up_count();
      test_pause_resume();
      test_up_terminal();
      test_down_count();
      test_load_clamp_clear();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Parametrised stopwatch/timer core. Replaces the fixed 1 Hz, up-only, binary seconds counter.
- Generates its own sub-second tick from the system clock.
- Counts up (stopwatch) or down (countdown timer) in MM:SS.ff form, with run/pause, clear and per-digit preload.
- Sits between the debounced button/switch logic and the 7-segment display driver. Outputs BCD digits plus a binary total-seconds value.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- TICK_HZ, 100, sub-second resolution in ticks per second (2..1000). CLK_HZ must be divisible by TICK_HZ.
- MAX_MIN, 99, maximum minutes value (1..99).
- Localparam PRESC = CLK_HZ/TICK_HZ.
- Localparam FRAC_W = $clog2(TICK_HZ).
- Localparam SEC_W = $clog2(MAX_MIN*60+60).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start_stop  in  1  single-cycle pulse, already debounced.
- clear  in  1  single-cycle pulse, zeroes the count.
- mode_down  in  1  1 = countdown; sampled only in IDLE on start.
- ld_en  in  1  single-cycle digit-load strobe.
- ld_sel  in  2  digit select: 0 = sec_ones, 1 = sec_tens, 2 = min_ones, 3 = min_tens.
- ld_val  in  4  BCD value to load.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD digits.
- frac  out  FRAC_W  sub-second tick count, 0..TICK_HZ-1.
- total_sec  out  SEC_W  minutes*60+seconds, binary.
- running  out  1  high in RUN.
- done  out  1  one-cycle pulse on terminal count.

Behaviour:
- Reset (rst_n low, async): all digits, frac, total_sec and the prescaler go to 0. State = IDLE; running = 0; done = 0.
- States:
  - IDLE: start_stop → RUN. The direction is latched from mode_down and the prescaler is cleared.
  - RUN: start_stop → PAUSE; terminal count → DONE.
  - PAUSE: start_stop → RUN. The prescaler is held, not cleared, so resume is phase-exact.
  - DONE: start_stop is ignored; clear → IDLE.
  - clear in any state → IDLE with the count zeroed.
- Priority within one cycle: clear > start_stop > ld_en.
- Prescaler: counts 0..PRESC-1 in RUN only. The tick is asserted when it wraps. First tick after start arrives PRESC cycles after the start_stop pulse.
- Up count, per tick:
  - frac increments; at TICK_HZ-1 it wraps to 0 and carries into seconds.
  - sec_ones 9→0 carries; sec_tens 5→0 carries into minutes.
  - min_ones 9→0 carries into min_tens.
- Up terminal: at MAX_MIN:59.(TICK_HZ-1), the next tick does not wrap. The count holds at the max, state → DONE, and done pulses in the same cycle the tick is consumed.
- Down count: mirror of up. frac 0 borrows → TICK_HZ-1; sec 00 borrows → 59.
  - Reaching 00:00.0 → DONE, with done pulsing on that tick.
- Start in down mode with count already 00:00.0: the next cycle goes to DONE with done = 1. No tick wait.
- Digit load: accepted only in IDLE or PAUSE; ignored in RUN/DONE.
  - Values are clamped: sec_tens max 5; other digits max 9.
  - Minutes that would exceed MAX_MIN are clamped to MAX_MIN.
  - frac is zeroed on any load.
- total_sec is registered and updated on the same cycle as the digits (1-cycle-consistent with them).
- running is combinational from state.
- done is registered and exactly one cycle wide.

Decomposition:
- Package stopwatch_pkg contains:
  - state enum {IDLE, RUN, PAUSE, DONE};
  - ld_sel encodings SEL_SEC_ONES..SEL_MIN_TENS;
  - BCD digit typedef (logic [3:0]);
  - clamp limits SEC_TENS_MAX = 5, DIGIT_MAX = 9.
- One sub-module: tick_gen(clk, rst_n, en, clr, tick), parametrised by PRESC. It holds the prescaler and is reused later by the display refresh and adjust-blink logic.

Test Plan:
- Params CLK_HZ=1000, TICK_HZ=10 (PRESC=100), MAX_MIN=99. Reset, then start_stop in up mode → first frac=1 exactly 100 cycles later; after 10,000 cycles reads 00:10.0 with total_sec=10.
- Run 00:05.3, pulse start_stop to PAUSE, wait 500 cycles, resume → count frozen during PAUSE; next tick lands 100 minus the consumed prescaler phase after resume (phase preserved).
- Preload 99:59 via four ld_en writes in IDLE, up mode, run 10 ticks → done pulses once at the tick after 99:59.9; display holds 99:59.9; state DONE; start_stop ignored.
- Preload 01:00 (down mode), run 1 tick → 00:59.9; continue to 00:00.0 → done pulse; total_sec=0.
- ld_val=7 on sec_tens → sec_tens=5. In the same cycle, clear and start_stop together → clear wins: IDLE, all digits 0.
- Assert rst_n low mid-RUN between clock edges → outputs go to 0 immediately (async); running=0 and no done pulse.
